// File: rtl/fetch_stage_ifid.sv
// Instruction fetch stage with an IF/ID pipeline register, downstream stall and redirect.
// Define FETCH_PERF_CNT_EN to add the fetch_count accepted-instruction counter port.
module fetch_stage_ifid (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic [31:0] PCOUT,
   output logic [31:0] INST_IF_ID,
   output logic [31:0] pc_IF_ID,
   output logic        valid_IF_ID
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] STALL = 2'd2;
   localparam logic [1:0] REDIR = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_ifid_q, pc_ifid_d;
   logic        valid_q, valid_d;
   logic        load;
   logic [31:0] redir_target;

   // Masking keeps the fetch PC word aligned whatever the redirect source sends.
   assign redir_target = redirect_pc & ~32'h3;
   assign load = !redirect_valid && (state_q != IDLE) && !id_stall;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      pc_ifid_d = pc_ifid_q;
      valid_d   = valid_q;
      if (redirect_valid) begin
         pc_d    = redir_target;
         inst_d  = 32'h0;
         valid_d = 1'b0;
         state_d = REDIR;
      end else if (state_q == IDLE) begin
         valid_d = 1'b0;
         state_d = RUN;
      end else if (load) begin
         inst_d    = imem_rdata;
         pc_ifid_d = pc_q;
         valid_d   = 1'b1;
         pc_d      = pc_q + 32'd4;
         state_d   = RUN;
      end else begin
         state_d = (state_q == REDIR) ? REDIR : STALL;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= 32'h0;
         inst_q    <= 32'h0;
         pc_ifid_q <= 32'h0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         pc_ifid_q <= pc_ifid_d;
         valid_q   <= valid_d;
      end
   end

   assign imem_addr   = pc_q;
   assign PCOUT       = pc_q;
   assign INST_IF_ID  = inst_q;
   assign pc_IF_ID    = pc_ifid_q;
   assign valid_IF_ID = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts exactly the edges that load a real instruction into IF/ID.
   always_comb begin
      cnt_d = cnt_q;
      if (load) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= 32'h0;
      else      cnt_q <= cnt_d;
   end

   assign fetch_count = cnt_q;
`endif

endmodule
